id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage MIPS pipeline, sitting directly downstream of the decode control unit.
- Latches the decoded control bundle (RegDst, Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite) together with operands and register indices from ID, and presents them to EX.
- Contains the load-use hazard detector: generates the stall to PC and IF/ID, and inserts bubbles on stall or branch flush.
- Keeps saturating counters of inserted bubbles for performance debug.

---
 rtl/id_ex_stage.sv | 156 +++++++++++++++
 tb/tb_id_ex_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS pipeline.
// Latches the decoded control bundle, operands and register indices from ID,
// detects load-use hazards, inserts bubbles on stall or branch flush, and
// keeps saturating counters of inserted bubbles for performance debug.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_RegDst,
  input  logic              id_Branch,
  input  logic              id_MemRead,
  input  logic              id_MemtoReg,
  input  logic              id_MemWrite,
  input  logic              id_ALUSrc,
  input  logic              id_RegWrite,
  input  logic [1:0]        id_ALUOp,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_RegDst,
  output logic              ex_Branch,
  output logic              ex_MemRead,
  output logic              ex_MemtoReg,
  output logic              ex_MemWrite,
  output logic              ex_ALUSrc,
  output logic              ex_RegWrite,
  output logic [1:0]        ex_ALUOp,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [CNT_W-1:0]  load_use_bubbles,
  output logic [CNT_W-1:0]  flush_bubbles
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Control bundle packed as {RegDst, Branch, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite}
  logic [8:0]        ctrl_in_s;
  logic [8:0]        ctrl_d, ctrl_q;
  logic              valid_d, valid_q;
  logic [DATA_W-1:0] pc4_q, rs_data_q, rt_data_q, imm_q;
  logic [4:0]        rs_q, rt_q, rd_q;
  logic [CNT_W-1:0]  lub_d, lub_q;
  logic [CNT_W-1:0]  fb_d, fb_q;
  logic              uses_rt_s;
  logic              hazard_s;
  logic              bubble_s;

  assign ctrl_in_s = {id_RegDst, id_Branch, id_MemRead, id_MemtoReg,
                      id_ALUOp, id_MemWrite, id_ALUSrc, id_RegWrite};

  // Load-use hazard detection: a load in EX whose destination is read by the ID instruction.
  always_comb begin
    uses_rt_s = id_RegDst | id_MemWrite | id_Branch;
    hazard_s  = valid_q & ctrl_q[6] & id_valid & (rt_q != 5'd0) &
                ((rt_q == id_rs) | (uses_rt_s & (rt_q == id_rt)));
    // A flushed ID instruction is discarded, so it must not be held.
    stall     = hazard_s & ~flush;
    bubble_s  = flush | stall;
  end

  // Next-state for valid, control bundle and the saturating bubble counters.
  always_comb begin
    valid_d = id_valid;
    ctrl_d  = ctrl_in_s;
    lub_d   = lub_q;
    fb_d    = fb_q;
    if (bubble_s) begin
      valid_d = 1'b0;
      ctrl_d  = 9'd0;
    end else begin
      valid_d = id_valid;
      ctrl_d  = ctrl_in_s;
    end
    // Flush takes priority, so a simultaneous hazard only counts as a flush bubble.
    if (flush) begin
      if (fb_q != CNT_MAX) begin
        fb_d = fb_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        fb_d = fb_q;
      end
    end else if (stall) begin
      if (lub_q != CNT_MAX) begin
        lub_d = lub_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        lub_d = lub_q;
      end
    end else begin
      fb_d  = fb_q;
      lub_d = lub_q;
    end
  end

  // Pipeline register: data and indices always load; valid/control carry the bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      ctrl_q    <= 9'd0;
      pc4_q     <= {DATA_W{1'b0}};
      rs_data_q <= {DATA_W{1'b0}};
      rt_data_q <= {DATA_W{1'b0}};
      imm_q     <= {DATA_W{1'b0}};
      rs_q      <= 5'd0;
      rt_q      <= 5'd0;
      rd_q      <= 5'd0;
      lub_q     <= {CNT_W{1'b0}};
      fb_q      <= {CNT_W{1'b0}};
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      pc4_q     <= id_pc4;
      rs_data_q <= id_rs_data;
      rt_data_q <= id_rt_data;
      imm_q     <= id_imm;
      rs_q      <= id_rs;
      rt_q      <= id_rt;
      rd_q      <= id_rd;
      lub_q     <= lub_d;
      fb_q      <= fb_d;
    end
  end

  assign ex_valid         = valid_q;
  assign ex_RegDst        = ctrl_q[8];
  assign ex_Branch        = ctrl_q[7];
  assign ex_MemRead       = ctrl_q[6];
  assign ex_MemtoReg      = ctrl_q[5];
  assign ex_ALUOp         = ctrl_q[4:3];
  assign ex_MemWrite      = ctrl_q[2];
  assign ex_ALUSrc        = ctrl_q[1];
  assign ex_RegWrite      = ctrl_q[0];
  assign ex_pc4           = pc4_q;
  assign ex_rs_data       = rs_data_q;
  assign ex_rt_data       = rt_data_q;
  assign ex_imm           = imm_q;
  assign ex_rs            = rs_q;
  assign ex_rt            = rt_q;
  assign ex_rd            = rd_q;
  assign load_use_bubbles = lub_q;
  assign flush_bubbles    = fb_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver pushes the hand-computed EX
// state expected after each edge; a monitor pops and compares after the edge.
module tb_id_ex_stage;

  localparam logic [8:0] C_RTYPE = 9'h111;
  localparam logic [8:0] C_LW    = 9'h063;
  localparam logic [8:0] C_SW    = 9'h006;
  localparam logic [8:0] C_ADDI  = 9'h003;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid, flush;
  logic [8:0]  id_ctrl;
  logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        stall, ex_valid;
  logic        ex_RegDst, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite;
  logic [1:0]  ex_ALUOp;
  logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [15:0] load_use_bubbles, flush_bubbles;

  typedef struct {
    logic         v;
    logic [8:0]   c;
    logic [14:0]  idx;
    logic [127:0] dat;
    logic [31:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_RegDst(id_ctrl[8]), .id_Branch(id_ctrl[7]), .id_MemRead(id_ctrl[6]),
    .id_MemtoReg(id_ctrl[5]), .id_MemWrite(id_ctrl[2]), .id_ALUSrc(id_ctrl[1]),
    .id_RegWrite(id_ctrl[0]), .id_ALUOp(id_ctrl[4:3]),
    .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_RegDst(ex_RegDst), .ex_Branch(ex_Branch),
    .ex_MemRead(ex_MemRead), .ex_MemtoReg(ex_MemtoReg), .ex_MemWrite(ex_MemWrite),
    .ex_ALUSrc(ex_ALUSrc), .ex_RegWrite(ex_RegWrite), .ex_ALUOp(ex_ALUOp),
    .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .load_use_bubbles(load_use_bubbles), .flush_bubbles(flush_bubbles)
  );

  function automatic logic [8:0] ex_ctrl();
    return {ex_RegDst, ex_Branch, ex_MemRead, ex_MemtoReg, ex_ALUOp, ex_MemWrite, ex_ALUSrc, ex_RegWrite};
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Apply an ID bundle; data operands derive from the immediate.
  task automatic drive(input logic [8:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] imm, input logic v, input logic fl);
    id_ctrl    = c;
    id_rs      = rs;
    id_rt      = rt;
    id_rd      = rd;
    id_imm     = imm;
    id_pc4     = imm + 32'd4;
    id_rs_data = imm ^ 32'hDEAD_BEEF;
    id_rt_data = imm + 32'h0000_0100;
    id_valid   = v;
    flush      = fl;
  endtask

  // One cycle: drive ID, check stall before the edge, push the expected EX state.
  task automatic issue(input logic [8:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] imm, input logic v, input logic fl,
                       input logic e_stall, input logic e_v, input logic [8:0] e_c,
                       input logic [15:0] e_lub, input logic [15:0] e_fb);
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    drive(c, rs, rt, rd, imm, v, fl);
    #1;
    check("stall", {127'd0, stall}, {127'd0, e_stall});
    e.v   = e_v;
    e.c   = e_c;
    e.idx = {rs, rt, rd};
    e.dat = {imm + 32'd4, imm ^ 32'hDEAD_BEEF, imm + 32'h0000_0100, imm};
    e.cnt = {e_lub, e_fb};
    sb.push_back(e);
  endtask

  task automatic check_zero();
    check("rst_valid", {127'd0, ex_valid}, 128'd0);
    check("rst_ctrl", {119'd0, ex_ctrl()}, 128'd0);
    check("rst_idx", {113'd0, ex_rs, ex_rt, ex_rd}, 128'd0);
    check("rst_data", {ex_pc4, ex_rs_data, ex_rt_data, ex_imm}, 128'd0);
    check("rst_cnt", {96'd0, load_use_bubbles, flush_bubbles}, 128'd0);
  endtask

  // Monitor: compare the EX register state after every edge that has an expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ex_valid", {127'd0, ex_valid}, {127'd0, e.v});
        check("ex_ctrl", {119'd0, ex_ctrl()}, {119'd0, e.c});
        check("ex_idx", {113'd0, ex_rs, ex_rt, ex_rd}, {113'd0, e.idx});
        check("ex_data", {ex_pc4, ex_rs_data, ex_rt_data, ex_imm}, e.dat);
        check("counters", {96'd0, load_use_bubbles, flush_bubbles}, {96'd0, e.cnt});
      end
    end
  end

  // Watchdog against a stuck run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    drive(C_ADDI, 5'd2, 5'd3, 5'd0, 32'h0000_0010, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    check_zero();
    //    ctrl     rs     rt     rd     imm            v     fl    stall e_v   e_ctrl  lub    fb
    issue(C_ADDI,  5'd2,  5'd3,  5'd0,  32'h0000_0010, 1'b1, 1'b0, 1'b0, 1'b1, C_ADDI,  16'd0, 16'd0);
    issue(C_LW,    5'd1,  5'd5,  5'd0,  32'h0000_0020, 1'b1, 1'b0, 1'b0, 1'b1, C_LW,    16'd0, 16'd0);
    // add $7,$5,$6 behind lw $5: one bubble, then the add advances
    issue(C_RTYPE, 5'd5,  5'd6,  5'd7,  32'h0000_3820, 1'b1, 1'b0, 1'b1, 1'b0, 9'd0,    16'd1, 16'd0);
    issue(C_RTYPE, 5'd5,  5'd6,  5'd7,  32'h0000_3820, 1'b1, 1'b0, 1'b0, 1'b1, C_RTYPE, 16'd1, 16'd0);
    // lw $5 then addi rt=5 rs=4: addi does not read rt
    issue(C_LW,    5'd1,  5'd5,  5'd0,  32'h0000_0024, 1'b1, 1'b0, 1'b0, 1'b1, C_LW,    16'd1, 16'd0);
    issue(C_ADDI,  5'd4,  5'd5,  5'd0,  32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b1, C_ADDI,  16'd1, 16'd0);
    // lw $0 then R-type reading $0: never stalls
    issue(C_LW,    5'd1,  5'd0,  5'd0,  32'h0000_0028, 1'b1, 1'b0, 1'b0, 1'b1, C_LW,    16'd1, 16'd0);
    issue(C_RTYPE, 5'd0,  5'd2,  5'd9,  32'h0000_4820, 1'b1, 1'b0, 1'b0, 1'b1, C_RTYPE, 16'd1, 16'd0);
    // lw $5 then sw rt=5: sw reads rt, stalls once
    issue(C_LW,    5'd1,  5'd5,  5'd0,  32'h0000_002C, 1'b1, 1'b0, 1'b0, 1'b1, C_LW,    16'd1, 16'd0);
    issue(C_SW,    5'd1,  5'd5,  5'd0,  32'h0000_0030, 1'b1, 1'b0, 1'b1, 1'b0, 9'd0,    16'd2, 16'd0);
    issue(C_SW,    5'd1,  5'd5,  5'd0,  32'h0000_0030, 1'b1, 1'b0, 1'b0, 1'b1, C_SW,    16'd2, 16'd0);
    // hazard and flush together: flush wins, no stall
    issue(C_LW,    5'd1,  5'd5,  5'd0,  32'h0000_0034, 1'b1, 1'b0, 1'b0, 1'b1, C_LW,    16'd2, 16'd0);
    issue(C_RTYPE, 5'd5,  5'd6,  5'd7,  32'h0000_3820, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0,    16'd2, 16'd1);
    // id_valid=0: controls still load as presented
    issue(C_ADDI,  5'd2,  5'd3,  5'd0,  32'h0000_0040, 1'b0, 1'b0, 1'b0, 1'b0, C_ADDI,  16'd2, 16'd1);
    // drive flush_bubbles up to 16'hFFFE
    for (int i = 0; i < 65533; i++) begin
      @(negedge clk);
      drive(C_ADDI, 5'd2, 5'd3, 5'd0, 32'h0000_0050, 1'b1, 1'b1);
    end
    issue(C_ADDI,  5'd2,  5'd3,  5'd0,  32'h0000_0060, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0,    16'd2, 16'hFFFF);
    issue(C_ADDI,  5'd2,  5'd3,  5'd0,  32'h0000_0061, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0,    16'd2, 16'hFFFF);
    issue(C_ADDI,  5'd2,  5'd3,  5'd0,  32'h0000_0062, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0,    16'd2, 16'hFFFF);
    issue(C_ADDI,  5'd2,  5'd3,  5'd0,  32'h0000_0070, 1'b1, 1'b0, 1'b0, 1'b1, C_ADDI,  16'd2, 16'hFFFF);
    // reset mid-run while ex_RegWrite=1 and counters nonzero
    @(negedge clk);
    rst = 1'b1;
    drive(C_LW, 5'd1, 5'd8, 5'd0, 32'h0000_0080, 1'b1, 1'b0);
    #1;
    check_zero();
    // first edge after release captures the ID bundle
    issue(C_LW,    5'd1,  5'd8,  5'd0,  32'h0000_0080, 1'b1, 1'b0, 1'b0, 1'b1, C_LW,    16'd0, 16'd0);
    repeat (2) @(negedge clk);
    check("sb_drain", 128'(sb.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
